time_keeper: RTL
================

Name: time_keeper

Overview:
- 12-hour time-of-day and alarm-time register block. It sits directly upstream of the alarm comparator and drives its tmin/thrs/tpm and amin/ahrs/apm inputs.
- Counts seconds, minutes and hours with AM/PM on a one-cycle-per-second strobe.
- Supports time-set and alarm-set modes with minute/hour advance buttons.
- Does not generate buzz or gate it; that belongs downstream.

Parameters:
- SEC_MAX, 59, last seconds value before wrap
- MIN_MAX, 59, last minutes value before wrap
- HRS_MAX, 12, highest hour value; hours run 1..HRS_MAX

Ports:
- Pulse  input  1  system clock, rising-edge active
- Reset_n  input  1  asynchronous active-low reset
- tick  input  1  one-cycle strobe, once per second; all state updates happen only on cycles where tick=1
- Timeset  input  1  level: time-set mode
- Alarmset  input  1  level: alarm-set mode
- Minadv  input  1  level: advance minutes by one per tick while in a set mode
- Hrsadv  input  1  level: advance hours by one per tick while in a set mode
- tsec  output  7  current seconds, 0..59
- tmin  output  7  current minutes, 0..59
- thrs  output  7  current hours, 1..12
- tpm  output  1  1 = PM
- amin  output  7  alarm minutes, 0..59
- ahrs  output  7  alarm hours, 1..12
- apm  output  1  1 = PM

Behaviour:
- Reset (Reset_n=0, asynchronous, any time):
  - tsec=0, tmin=0, thrs=12, tpm=0.
  - amin=0, ahrs=12, apm=0.
  - Mid-operation reset discards any set in progress.
- All outputs are registered. An update is visible the cycle after the qualifying tick edge. Nothing changes when tick=0.
- Mode priority: Timeset > Alarmset > RUN.
  - Timeset=Alarmset=1 behaves as time-set only.
  - The mode is decoded combinationally each tick, so no FSM latency is added.
- RUN mode (both set inputs 0):
  - tsec increments each tick.
  - tsec 59->0 carries: tmin increments.
  - tmin 59->0 (with carry) carries: thrs increments.
  - thrs 11->12 toggles tpm. thrs 12->1 does not toggle.
  - Minadv/Hrsadv are ignored.
  - Full rollover 11:59:59 PM -> 12:00:00 AM on one tick.
- TIMESET mode:
  - tsec forced to 0 on each tick.
  - Minadv=1: tmin +1 with wrap 59->0, no carry into hours.
  - Hrsadv=1: thrs +1 with the same 11->12 PM toggle and 12->1 wrap.
  - Both high: both advance on the same tick, independently.
  - Alarm registers hold.
- ALARMSET mode:
  - Same advance rules applied to amin/ahrs/apm.
  - Time keeps running exactly as in RUN mode.
- Leaving TIMESET resumes counting from tsec=0 on the next tick.
- Counters never take illegal values: thrs is never 0 and never >12; minutes and seconds are never >59.
- Width rule: values are binary in the low bits; upper unused bits are 0.

Decomposition:
- Shared package holds the SEC_MAX/MIN_MAX/HRS_MAX defaults and a mode enum (RUN, TSET, ASET) used by this block and the top level.
- One natural sub-module: mod_counter.
  - Parameterized lo/hi bounds; inputs en and inc.
  - Outputs the value and a wrap pulse.
  - Instantiated for seconds, time minutes, time hours, alarm minutes and alarm hours.
  - The PM toggle logic stays in time_keeper.

Test Plan:
- Reset_n pulsed low between edges -> outputs immediately 12:00:00 AM and alarm 12:00 AM; held with tick=1 -> no change.
- RUN from 11:59:58 PM, 2 ticks -> 11:59:59 PM, then 12:00:00 AM (tpm 1->0); a further 3600 ticks -> 1:00:00 AM with tpm=0.
- Timeset=1, Hrsadv=1, Minadv=1 from 12:00 AM, 13 ticks -> 1:13, tpm=1, tsec=0; minutes 59->0 during set leaves thrs unchanged.
- Alarmset=1, Hrsadv=1 from reset, 11 ticks -> ahrs=11, apm=0; 1 more -> ahrs=12, apm=1; time meanwhile advanced by 12 s.
- Timeset=Alarmset=1, Minadv=1, 5 ticks -> tmin=5, amin=0.
- tick=0 for 100 cycles with all inputs toggling -> no output change; Reset_n asserted mid set-sequence -> reset values and no further advance until release.

Source files
------------

// File: rtl/time_keeper_pkg.sv
// Shared defaults and mode decode for the 12-hour time/alarm register block.
package time_keeper_pkg;

  localparam int unsigned DEF_SEC_MAX = 59;
  localparam int unsigned DEF_MIN_MAX = 59;
  localparam int unsigned DEF_HRS_MAX = 12;
  localparam int unsigned VAL_W       = 7;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    TSET = 2'd1,
    ASET = 2'd2
  } mode_e;

  // Time-set wins over alarm-set; neither means free running.
  function automatic mode_e decode_mode(input logic timeset, input logic alarmset);
    if (timeset)       return TSET;
    else if (alarmset) return ASET;
    else               return RUN;
  endfunction

endpackage

// File: rtl/time_keeper_mod_counter.sv
// Bounded LO..HI counter with synchronous clear and a wrap pulse on HI->LO.
module mod_counter #(
  parameter int unsigned W   = 7,
  parameter int unsigned LO  = 0,
  parameter int unsigned HI  = 59,
  parameter int unsigned RST = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         wrap_c
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= W'(RST);
    end else if (en) begin
      if (clr)
        value <= W'(LO);
      else if (inc)
        value <= (value == W'(HI)) ? W'(LO) : value + W'(1);
    end
  end

  always_comb begin
    wrap_c = en & inc & ~clr & (value == W'(HI));
  end

endmodule

// File: rtl/time_keeper.sv
// 12-hour time-of-day and alarm registers advanced on a once-per-second tick.
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int unsigned SEC_MAX = DEF_SEC_MAX,
  parameter int unsigned MIN_MAX = DEF_MIN_MAX,
  parameter int unsigned HRS_MAX = DEF_HRS_MAX
) (
  input  logic             Pulse,
  input  logic             Reset_n,
  input  logic             tick,
  input  logic             Timeset,
  input  logic             Alarmset,
  input  logic             Minadv,
  input  logic             Hrsadv,
  output logic [VAL_W-1:0] tsec,
  output logic [VAL_W-1:0] tmin,
  output logic [VAL_W-1:0] thrs,
  output logic             tpm,
  output logic [VAL_W-1:0] amin,
  output logic [VAL_W-1:0] ahrs,
  output logic             apm
);

  mode_e mode_c;
  logic  sec_inc, sec_clr, sec_wrap;
  logic  tmin_inc, tmin_wrap, thrs_inc, thrs_wrap;
  logic  amin_inc, amin_wrap, ahrs_inc, ahrs_wrap;
  logic  unused_wraps;

  // Mode and per-counter advance requests, decoded fresh every tick.
  always_comb begin
    mode_c   = decode_mode(Timeset, Alarmset);
    sec_clr  = (mode_c == TSET);
    sec_inc  = (mode_c != TSET);
    tmin_inc = (mode_c == TSET) ? Minadv : sec_wrap;
    thrs_inc = (mode_c == TSET) ? Hrsadv : tmin_wrap;
    amin_inc = (mode_c == ASET) & Minadv;
    ahrs_inc = (mode_c == ASET) & Hrsadv;
  end

  assign unused_wraps = &{1'b0, thrs_wrap, amin_wrap, ahrs_wrap};

  mod_counter #(.W(VAL_W), .LO(0), .HI(SEC_MAX), .RST(0)) u_tsec (
    .clk(Pulse), .rst_n(Reset_n), .en(tick), .inc(sec_inc), .clr(sec_clr),
    .value(tsec), .wrap_c(sec_wrap)
  );

  mod_counter #(.W(VAL_W), .LO(0), .HI(MIN_MAX), .RST(0)) u_tmin (
    .clk(Pulse), .rst_n(Reset_n), .en(tick), .inc(tmin_inc), .clr(1'b0),
    .value(tmin), .wrap_c(tmin_wrap)
  );

  mod_counter #(.W(VAL_W), .LO(1), .HI(HRS_MAX), .RST(HRS_MAX)) u_thrs (
    .clk(Pulse), .rst_n(Reset_n), .en(tick), .inc(thrs_inc), .clr(1'b0),
    .value(thrs), .wrap_c(thrs_wrap)
  );

  mod_counter #(.W(VAL_W), .LO(0), .HI(MIN_MAX), .RST(0)) u_amin (
    .clk(Pulse), .rst_n(Reset_n), .en(tick), .inc(amin_inc), .clr(1'b0),
    .value(amin), .wrap_c(amin_wrap)
  );

  mod_counter #(.W(VAL_W), .LO(1), .HI(HRS_MAX), .RST(HRS_MAX)) u_ahrs (
    .clk(Pulse), .rst_n(Reset_n), .en(tick), .inc(ahrs_inc), .clr(1'b0),
    .value(ahrs), .wrap_c(ahrs_wrap)
  );

  // AM/PM flips on the 11 -> 12 step only; 12 -> 1 keeps the half-day.
  always_ff @(posedge Pulse or negedge Reset_n) begin
    if (!Reset_n) begin
      tpm <= 1'b0;
      apm <= 1'b0;
    end else if (tick) begin
      if (thrs_inc && thrs == VAL_W'(HRS_MAX - 1)) tpm <= ~tpm;
      if (ahrs_inc && ahrs == VAL_W'(HRS_MAX - 1)) apm <= ~apm;
    end
  end

endmodule
